axi4_slave_mem: RTL and testbench

AXI4 memory-mapped responder: the target end of the AXI4 interface driven by the team's AXI master BFM. Sits inside the simulated system as the memory target for single and burst read/write traffic. Accepts the AW/W/B and AR/R channels, stores data in an internal word array with byte strobes, and echoes transaction IDs. Write and read paths run as independent state machines, each with one outstanding transaction.

---
 rtl/axi4_slave_mem.sv | 199 +++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) engines,
// each handling one outstanding burst, over a byte-strobed word array.
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 18,
  parameter int MEM_WORDS  = 256
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [2:0] SIZE_FULL = 3'(OFF_W);
  localparam logic [1:0] RESP_OK = 2'b00, RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  w_state_e w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d, bid_q, bid_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                wfixed_q, wfixed_d, wsize_err_q, wsize_err_d, werr_q, werr_d;
  logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                w_we, w_beat_last;

  r_state_e r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [IDX_W-1:0]      ridx_q, ridx_d, ar_idx, rd_idx;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic                  rfixed_q, rfixed_d, rsize_err_q, rsize_err_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;

  // Byte-offset and upper address bits are deliberately ignored (aligned, aliased access).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr, araddr};

  assign w_beat_last = (wcnt_q == wlen_q);
  assign ar_idx      = araddr[OFF_W +: IDX_W];
  // Single read port: the AR address in idle, the running index while streaming.
  assign rd_idx      = (r_state_q == R_IDLE) ? ar_idx : ridx_q;
  assign rd_word     = mem[rd_idx];

  // Write engine: capture AW, absorb len+1 beats, then hold B until accepted.
  always_comb begin
    w_state_d = w_state_q;  wid_d = wid_q;  widx_d = widx_q;  wlen_d = wlen_q;
    wcnt_d = wcnt_q;  wfixed_d = wfixed_q;  wsize_err_d = wsize_err_q;  werr_d = werr_q;
    awready_d = awready_q;  wready_d = wready_q;  bvalid_d = bvalid_q;
    bid_d = bid_q;  bresp_d = bresp_q;  w_we = 1'b0;
    case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        wid_d       = awid;
        widx_d      = awaddr[OFF_W +: IDX_W];
        wlen_d      = awlen;
        wcnt_d      = 8'd0;
        wfixed_d    = (awburst == 2'b00);
        wsize_err_d = (awsize != SIZE_FULL);
        werr_d      = (awsize != SIZE_FULL) || (awburst == 2'b11);
        awready_d   = 1'b0;
        wready_d    = 1'b1;
        w_state_d   = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        // Size errors still consume beats but leave memory untouched.
        w_we   = !wsize_err_q;
        // wlast only flags errors; the beat count alone ends the burst.
        if (wlast != w_beat_last) werr_d = 1'b1;
        widx_d = wfixed_q ? widx_q : widx_q + IDX_W'(1);
        wcnt_d = wcnt_q + 8'd1;
        if (w_beat_last) begin
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bid_d     = wid_q;
          bresp_d   = (werr_q || (wlast != w_beat_last)) ? RESP_SLVERR : RESP_OK;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (bready) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read engine: fetch on AR so beat 0 is valid next cycle, then one beat per rready.
  always_comb begin
    r_state_d = r_state_q;  rid_d = rid_q;  ridx_d = ridx_q;  rlen_d = rlen_q;
    rcnt_d = rcnt_q;  rfixed_d = rfixed_q;  rsize_err_d = rsize_err_q;
    arready_d = arready_q;  rvalid_d = rvalid_q;  rlast_d = rlast_q;
    rresp_d = rresp_q;  rdata_d = rdata_q;
    case (r_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        rid_d       = arid;
        rlen_d      = arlen;
        rcnt_d      = 8'd0;
        rfixed_d    = (arburst == 2'b00);
        rsize_err_d = (arsize != SIZE_FULL);
        rresp_d     = ((arsize != SIZE_FULL) || (arburst == 2'b11)) ? RESP_SLVERR : RESP_OK;
        rdata_d     = (arsize != SIZE_FULL) ? '0 : rd_word;
        ridx_d      = (arburst == 2'b00) ? ar_idx : ar_idx + IDX_W'(1);
        rvalid_d    = 1'b1;
        rlast_d     = (arlen == 8'd0);
        arready_d   = 1'b0;
        r_state_d   = R_DATA;
      end
      R_DATA: if (rvalid_q && rready) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rdata_d = rsize_err_q ? '0 : rd_word;
          ridx_d  = rfixed_q ? ridx_q : ridx_q + IDX_W'(1);
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = ((rcnt_q + 8'd1) == rlen_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and output registers for both engines.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      w_state_q <= W_IDLE;  wid_q <= '0;  widx_q <= '0;  wlen_q <= '0;  wcnt_q <= '0;
      wfixed_q <= 1'b0;  wsize_err_q <= 1'b0;  werr_q <= 1'b0;
      awready_q <= 1'b1;  wready_q <= 1'b0;  bvalid_q <= 1'b0;  bid_q <= '0;  bresp_q <= '0;
      r_state_q <= R_IDLE;  rid_q <= '0;  ridx_q <= '0;  rlen_q <= '0;  rcnt_q <= '0;
      rfixed_q <= 1'b0;  rsize_err_q <= 1'b0;
      arready_q <= 1'b1;  rvalid_q <= 1'b0;  rlast_q <= 1'b0;  rresp_q <= '0;  rdata_q <= '0;
    end else begin
      w_state_q <= w_state_d;  wid_q <= wid_d;  widx_q <= widx_d;  wlen_q <= wlen_d;
      wcnt_q <= wcnt_d;  wfixed_q <= wfixed_d;  wsize_err_q <= wsize_err_d;  werr_q <= werr_d;
      awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;
      bid_q <= bid_d;  bresp_q <= bresp_d;
      r_state_q <= r_state_d;  rid_q <= rid_d;  ridx_q <= ridx_d;  rlen_q <= rlen_d;
      rcnt_q <= rcnt_d;  rfixed_q <= rfixed_d;  rsize_err_q <= rsize_err_d;
      arready_q <= arready_d;  rvalid_q <= rvalid_d;  rlast_q <= rlast_d;
      rresp_q <= rresp_d;  rdata_q <= rdata_d;
    end
  end

  // Byte-strobed storage; contents survive reset. Same-cycle reads see the old word.
  always_ff @(posedge clk_clk) begin
    for (int b = 0; b < STRB_W; b++)
      if (w_we && !reset_reset && wstrb[b]) mem[widx_q][b*8 +: 8] <= wdata[b*8 +: 8];
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomized bench for axi4_slave_mem against a word-array/queue model.
module tb_axi4_slave_mem;
  logic clk_clk = 1'b0, reset_reset = 1'b1;
  logic [17:0] awid = '0, arid = '0, bid, rid;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;

  always #5 clk_clk = ~clk_clk;

  axi4_slave_mem dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed { logic [17:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [17:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int vectors = 0, miscompares = 0;
  logic [31:0] model_mem [256];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare whatever the DUT presents on B/R against the head of the expected queues.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (bvalid) begin
        if (b_q.size() == 0) chk("b_unexpected", {63'd0, bvalid}, 64'd0);
        else begin
          chk("bid", bid, b_q[0].id);
          chk("bresp", bresp, b_q[0].resp);
          if (bready) void'(b_q.pop_front());
        end
      end
      if (rvalid) begin
        if (r_q.size() == 0) chk("r_unexpected", {63'd0, rvalid}, 64'd0);
        else begin
          chk("rid", rid, r_q[0].id);
          chk("rdata", rdata, r_q[0].data);
          chk("rresp", rresp, r_q[0].resp);
          chk("rlast", rlast, r_q[0].last);
          if (rready) void'(r_q.pop_front());
        end
      end
    end
  end

  // Entered and left at posedge+1. last_at<0: correct wlast; rst_at>=0: reset instead of that beat.
  task automatic do_write(input logic [17:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int last_at, input int rst_at, input bit gaps);
    int idx, n;
    bit err, wl;
    idx = int'(addr[9:2]);
    err = (size != 3'd2) || (burst == 2'b11);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
    n = 0;
    do begin @(negedge clk_clk); n++; end while (!awready && n < 50);
    if (!awready) chk("aw_timeout", 64'd0, 64'd1);
    @(posedge clk_clk); #1 awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(3) == 0) begin wvalid = 0; @(posedge clk_clk); #1; end
      if (i == rst_at) begin
        wvalid = 0; reset_reset = 1;
        @(posedge clk_clk); #1 reset_reset = 0;
        @(negedge clk_clk);
        chk("rst_awready", awready, 1); chk("rst_wready", wready, 0); chk("rst_bvalid", bvalid, 0);
        @(posedge clk_clk); #1;
        return;
      end
      wl = (last_at < 0) ? (i == int'(len)) : (i == last_at);
      if (wl != (i == int'(len))) err = 1;
      wvalid = 1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = wl;
      n = 0;
      do begin @(negedge clk_clk); n++; end while (!wready && n < 50);
      if (!wready) chk("w_timeout", 64'd0, 64'd1);
      @(posedge clk_clk);
      if (size == 3'd2)
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) model_mem[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
      if (burst != 2'b00) idx = (idx + 1) % 256;
      #1;
    end
    wvalid = 0; wlast = 0;
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    @(negedge clk_clk); chk("b_latency", bvalid, 1);
    @(posedge clk_clk); #1;
    repeat ($urandom_range(2)) begin @(posedge clk_clk); #1; end
    bready = 1;
    n = 0;
    do begin @(negedge clk_clk); n++; end while (!bvalid && n < 50);
    if (!bvalid) chk("b_timeout", 64'd0, 64'd1);
    @(posedge clk_clk); #1 bready = 0;
    @(negedge clk_clk); chk("awready_back", awready, 1);
    @(posedge clk_clk); #1;
  endtask

  // rmode 0: rready held high, 1: alternating 1/0, 2: random.
  task automatic do_read(input logic [17:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int rmode);
    int idx, n, got, t;
    bit err;
    idx = int'(addr[9:2]);
    err = (size != 3'd2) || (burst == 2'b11);
    for (int i = 0; i <= int'(len); i++) begin
      r_q.push_back('{id: id, data: (size != 3'd2) ? 32'd0 : model_mem[idx],
                      resp: err ? 2'b10 : 2'b00, last: (i == int'(len))});
      if (burst != 2'b00) idx = (idx + 1) % 256;
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
    n = 0;
    do begin @(negedge clk_clk); n++; end while (!arready && n < 50);
    if (!arready) chk("ar_timeout", 64'd0, 64'd1);
    @(posedge clk_clk); #1 arvalid = 0;
    got = 0; n = 0; t = 0;
    rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b1 : 1'($urandom_range(1));
    @(negedge clk_clk); chk("r_latency", rvalid, 1);
    forever begin
      if (rmode == 0) chk("r_throughput", rvalid, 1);
      if (rvalid && rready) got++;
      n++;
      if (got > int'(len) || n > 2000) break;
      @(posedge clk_clk); #1;
      t++;
      rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(t % 2 == 0) : 1'($urandom_range(1));
      @(negedge clk_clk);
    end
    if (got <= int'(len)) chk("r_timeout", 64'd0, 64'd1);
    @(posedge clk_clk); #1 rready = 0;
    @(negedge clk_clk); chk("arready_back", arready, 1);
    @(posedge clk_clk); #1;
  endtask

  initial begin
    int len, last_at;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset = 0;
    @(negedge clk_clk);
    chk("reset_awready", awready, 1); chk("reset_arready", arready, 1);
    chk("reset_wready", wready, 0);   chk("reset_bvalid", bvalid, 0);
    chk("reset_rvalid", rvalid, 0);   chk("reset_rlast", rlast, 0);
    chk("reset_bresp", bresp, 0);     chk("reset_rresp", rresp, 0);
    chk("reset_bid", bid, 0);         chk("reset_rid", rid, 0);
    chk("reset_rdata", rdata, 0);
    @(posedge clk_clk); #1;

    // Fill every word so the model starts fully defined (also a 256-beat burst).
    for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(18'd1, 16'h0000, 8'd255, 3'd2, 2'b01, -1, -1, 1'b0);

    wbuf[0] = 32'h01010101; sbuf[0] = 4'hF;
    do_write(18'd0, 16'h0000, 8'd0, 3'd2, 2'b01, -1, -1, 1'b0);
    chk("pin_word0", model_mem[0], 32'h01010101);
    do_read(18'd5, 16'h0000, 8'd0, 3'd2, 2'b01, 0);

    wbuf[0] = 32'hAABBCCDD;
    do_write(18'd2, 16'h0004, 8'd0, 3'd2, 2'b01, -1, -1, 1'b0);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'h5;
    do_write(18'd2, 16'h0004, 8'd0, 3'd2, 2'b01, -1, -1, 1'b0);
    chk("pin_strobe", model_mem[1], 32'hAA22CC44);
    do_read(18'd3, 16'h0004, 8'd0, 3'd2, 2'b01, 0);

    for (int i = 0; i < 8; i++) begin wbuf[i] = i; sbuf[i] = 4'hF; end
    do_write(18'd7, 16'h0000, 8'd7, 3'd2, 2'b01, -1, -1, 1'b0);
    chk("pin_incr5", model_mem[5], 32'd5);
    do_read(18'd7, 16'h0000, 8'd7, 3'd2, 2'b01, 1);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + i;
    do_write(18'd8, 16'h03F8, 8'd3, 3'd2, 2'b01, -1, -1, 1'b0);
    chk("pin_wrap", model_mem[0], 32'hC0DE0002);
    do_read(18'd8, 16'h0400, 8'd0, 3'd2, 2'b01, 0);

    do_write(18'h2ABCD, 16'h0020, 8'd3, 3'd2, 2'b01, 1, -1, 1'b0);
    wbuf[0] = 32'hDEADBEEF;
    do_write(18'd4, 16'h0008, 8'd0, 3'd1, 2'b01, -1, -1, 1'b0);
    do_read(18'd4, 16'h0008, 8'd0, 3'd2, 2'b01, 0);
    do_read(18'd6, 16'h0010, 8'd3, 3'd2, 2'b11, 2);

    for (int i = 0; i < 8; i++) wbuf[i] = 32'h5A5A0000 + i;
    do_write(18'd9, 16'h0040, 8'd7, 3'd2, 2'b01, -1, 3, 1'b0);
    chk("pin_rst_beat2", model_mem[18], 32'h5A5A0002);
    do_read(18'd9, 16'h0040, 8'd7, 3'd2, 2'b01, 0);

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(15);
      if ($urandom_range(1) == 0) begin
        for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        last_at = ($urandom_range(5) == 0) ? int'($urandom_range(len)) : -1;
        do_write(18'($urandom), 16'($urandom), 8'(len),
                 ($urandom_range(5) == 0) ? 3'($urandom) : 3'd2, 2'($urandom),
                 last_at, -1, 1'b1);
      end else
        do_read(18'($urandom), 16'($urandom), 8'(len),
                ($urandom_range(5) == 0) ? 3'($urandom) : 3'd2, 2'($urandom), 2);
    end

    chk("b_queue_drained", 64'(b_q.size()), 64'd0);
    chk("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
